// File: rtl/sb_pkg.sv
// Shared constants and types for the register write scoreboard.
// Used by the per-register counter and by the scoreboard top level.
package sb_pkg;

  localparam int REG_IDX_W = 5;
  localparam int NREG      = 32;
  localparam int CNT_W     = 2;

  localparam logic [REG_IDX_W-1:0] ZERO_REG = 5'd0;

  typedef logic [CNT_W-1:0] sb_cnt_t;

endpackage

// File: rtl/sb_counter.sv
// Pending-write counter for one architectural register.
// Holds at zero on a decrement and at full scale on an increment.
module sb_counter #(
  parameter int W = sb_pkg::CNT_W
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  input  logic dec,
  output logic zero,
  output logic max
);

  logic [W-1:0] count;

  // Count register: reset/clear first, then net up/down movement.
  always_ff @(posedge clock) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc && !dec && !max) begin
      count <= count + {{(W-1){1'b0}}, 1'b1};
    end else if (dec && !inc && !zero) begin
      count <= count - {{(W-1){1'b0}}, 1'b1};
    end else begin
      count <= count;
    end
  end

  assign zero = (count == '0);
  assign max  = (count == '1);

endmodule

// File: rtl/reg_scoreboard.sv
// Tracks in-flight register writes between issue and writeback.
// Raises stall on source hazards or destination counter saturation.
module reg_scoreboard #(
  parameter int CNT_W = sb_pkg::CNT_W,
  parameter int NREG  = sb_pkg::NREG
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         flush,
  input  logic [sb_pkg::REG_IDX_W-1:0] rs,
  input  logic [sb_pkg::REG_IDX_W-1:0] rt,
  input  logic                         issue_valid,
  input  logic                         issue_wr,
  input  logic [sb_pkg::REG_IDX_W-1:0] issue_rd,
  input  logic                         wb_valid,
  input  logic [sb_pkg::REG_IDX_W-1:0] wb_rd,
  output logic                         stall,
  output logic [NREG-1:0]              busy_vec,
  output logic                         sb_error
);

  import sb_pkg::*;

  logic [NREG-1:0] zero_flag;
  logic [NREG-1:0] max_flag;
  logic            issue_req;
  logic            wb_req;
  logic            inc;
  logic            dec;
  logic            wb_err;

  // Hazard checks read only registered counter state, so a writeback
  // in this cycle does not release a dependent source until next cycle.
  assign issue_req = issue_valid && issue_wr && (issue_rd != ZERO_REG);
  assign stall     = ((rs != ZERO_REG) && !zero_flag[rs]) ||
                     ((rt != ZERO_REG) && !zero_flag[rt]) ||
                     (issue_req && max_flag[issue_rd]);

  assign inc    = issue_req && !stall;
  assign wb_req = wb_valid && (wb_rd != ZERO_REG);
  assign dec    = wb_req && !zero_flag[wb_rd];
  assign wb_err = wb_req && zero_flag[wb_rd];

  genvar i;
  generate
    for (i = 0; i < NREG; i++) begin : g_reg
      if (i == 0) begin : g_r0
        assign zero_flag[i] = 1'b1;
        assign max_flag[i]  = 1'b0;
      end else begin : g_cnt
        sb_counter #(.W(CNT_W)) u_cnt (
          .clock (clock),
          .reset (reset),
          .clr   (flush),
          .inc   (inc && (issue_rd == REG_IDX_W'(i))),
          .dec   (dec && (wb_rd == REG_IDX_W'(i))),
          .zero  (zero_flag[i]),
          .max   (max_flag[i])
        );
      end
    end
  endgenerate

  assign busy_vec = ~zero_flag;

  // Sticky underflow flag; only reset clears it, and a flushed wb is dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      sb_error <= 1'b0;
    end else if (!flush && wb_err) begin
      sb_error <= 1'b1;
    end else begin
      sb_error <= sb_error;
    end
  end

endmodule
